// File: rtl/uart_pkg.sv
// uart_pkg: shared UART byte width and arbiter state encoding.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, LOAD, SEND, ACK} arb_state_e;
endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// rr_pick: round-robin winner search starting one past the pointer.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               any_o
);
  always_comb begin
    onehot_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!any_o && req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
        onehot_o[(int'(ptr_i) + k) % NUM_REQ] = 1'b1;
        idx_o = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
        any_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one uart_tx among NUM_REQ byte streams,
// holding the grant for a whole packet so packets never interleave on the wire.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W = $clog2(NUM_REQ)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]             req_last_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic [UART_DATA_W-1:0]         tx_data_o,
  output logic                           tx_en_o,
  input  logic                           tx_ready_i,
  output logic                           busy_o
);
  arb_state_e r_state, w_next;
  logic [PTR_W-1:0] r_ptr, w_pick_idx, w_sel;
  logic [NUM_REQ-1:0] r_grant, w_pick_oh;
  logic [UART_DATA_W-1:0] r_buf, r_tx_data, w_lane;
  logic r_last, w_any, w_accept, w_send;

  rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .req_i   (req_valid_i),
    .ptr_i   (r_ptr),
    .onehot_o(w_pick_oh),
    .idx_o   (w_pick_idx),
    .any_o   (w_any)
  );

  // While locked the pointer already names the granted lane.
  assign w_sel = (r_state == IDLE) ? w_pick_idx : r_ptr;
  assign w_lane = req_data_i[UART_DATA_W*w_sel +: UART_DATA_W];
  assign w_accept = (r_state == IDLE && w_any) || (r_state == LOAD && |(req_valid_i & r_grant));
  assign w_send = r_state == SEND && tx_ready_i;

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, LOAD: w_next = w_accept ? SEND : r_state;
      SEND:       w_next = tx_ready_i ? ACK : SEND;
      ACK:        w_next = tx_ready_i ? ACK : (r_last ? IDLE : LOAD);
      default:    w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (r_state == IDLE) ? w_pick_oh : (r_state == LOAD) ? r_grant : '0;
    grant_o = r_grant;
    tx_en_o = w_send;
    tx_data_o = w_send ? r_buf : r_tx_data;
    busy_o = r_state != IDLE || |r_grant;
  end

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      r_ptr <= PTR_W'(NUM_REQ - 1);
      r_grant <= '0;
      r_buf <= '0;
      r_last <= 1'b0;
      r_tx_data <= '0;
    end else begin
      if (w_accept) begin
        r_buf <= w_lane;
        r_last <= req_last_i[w_sel];
      end
      if (r_state == IDLE && w_any) begin
        r_grant <= w_pick_oh;
        r_ptr <= w_pick_idx;
      end
      if (w_send) r_tx_data <= r_buf;
      if (r_state == ACK && !tx_ready_i && r_last) r_grant <= '0;
    end
endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares a single 8n1 `uart_tx` transmitter between `NUM_REQ` byte-stream requesters. It sits between the requesters (debug/log sources, command responders) and the `uart_tx` instance. It owns the transmitter's `tx_en_i`/`tx_ready_o` handshake and holds a grant for the whole packet until the requester marks a byte as last, so packets from different sources never interleave on the wire.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be ≥2.
- `PTR_W`, default `$clog2(NUM_REQ)`: width of the internal round-robin pointer and grant index.
- `clk_i` in 1: clock.
- `reset_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in NUM_REQ: requester i has a byte on its lane.
- `req_data_i` in 8*NUM_REQ: byte lane i is `[8*i+7:8*i]`.
- `req_last_i` in NUM_REQ: the byte on lane i ends its packet.
- `req_ready_o` out NUM_REQ: one-hot; byte on lane i is accepted this cycle when `req_valid_i[i]` is also high.
- `grant_o` out NUM_REQ: one-hot owner of the transmitter; all-zero when unlocked.
- `tx_data_o` out 8: byte to transmitter `data_i`.
- `tx_en_o` out 1: one-cycle start pulse to transmitter `tx_en_i`.
- `tx_ready_i` in 1: from transmitter `tx_ready_o`; high while it is idle.
- `busy_o` out 1: high whenever state ≠ IDLE or `grant_o` ≠ 0.

## Operation
- Reset values: `req_ready_o`=0, `grant_o`=0, `tx_data_o`=0x00, `tx_en_o`=0, `busy_o`=0, state=IDLE, pointer=NUM_REQ-1 (requester 0 wins first).
- Byte buffer: 8-bit register, plus a `last` flag register.
- IDLE (unlocked):
  - Pick the first i with `req_valid_i[i]`, searching from pointer+1 modulo NUM_REQ.
  - `req_ready_o` is combinational one-hot to the winner.
  - Latch the byte and last flag; set `grant_o`; pointer ← winner; go to SEND.
  - No valid → stay, `req_ready_o`=0.
- LOAD (locked):
  - `req_ready_o` = `grant_o` (combinational).
  - When `req_valid_i` is high on the granted lane: latch the byte and last flag, go to SEND.
  - Other requesters are ignored.
- SEND:
  - When `tx_ready_i`=1: drive `tx_en_o`=1 and `tx_data_o`=buffer for exactly one cycle, then go to ACK.
  - Otherwise wait.
- ACK:
  - Wait for `tx_ready_i`=0, which confirms the transmitter left idle.
  - Then: last flag set → clear `grant_o` and go to IDLE; otherwise go to LOAD.
- `tx_data_o` holds its value between sends.
- Requesters must hold data and last stable while valid is high and ready is low.

## Timing
- Acceptance to `tx_en_o`: 1 cycle minimum (IDLE/LOAD accept in cycle N, pulse in N+1 if `tx_ready_i`=1).
- The transmitter drops ready the cycle after `tx_en`, so ACK normally lasts 1 cycle.
- The next byte is accepted while the current byte is still on the wire. SEND then stalls until `tx_ready_i` rises after the stop bit, so the line has no added idle gap beyond the transmitter's own IDLE cycle.
- Simultaneous valid from several requesters: only the round-robin winner sees ready.
- A new request arriving during a locked packet waits until the packet's last byte reaches ACK.
- Requester deasserts valid mid-packet: remain in LOAD indefinitely and keep the lock. No timeout.
- `tx_ready_i` already low on entry to SEND: wait. `tx_en_o` is never asserted while `tx_ready_i`=0.
- Reset mid-packet: all outputs return to reset values immediately. The in-flight byte is dropped; the transmitter is reset by the same `reset_i`.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_W`=8.
  - Arbiter state encoding IDLE/LOAD/SEND/ACK (2 bits).
- Sub-module `rr_pick`: combinational, parameterized by NUM_REQ.
  - Inputs: request vector and pointer.
  - Outputs: one-hot winner, winner index, any-valid.
- Sequential logic stays in `uart_tx_arb`.

## Test plan
Bench: real `uart_tx` at CLOCK_FREQ=100_000_000, BAUD_RATE=10_000_000 (10 clocks/bit), with a line decoder.
- Reset release, no requests → all outputs 0, `tx_o` idles high, `busy_o`=0.
- Requester 2 sends 0xA5 with last=1 → one `tx_en_o` pulse with `tx_data_o`=0xA5 one cycle after ready; decoder sees 0xA5; `grant_o` returns to 0.
- Requesters 0, 1, 3 all valid with single-byte packets 0x10, 0x11, 0x13 → wire order 0x10, 0x11, 0x13. Repeat with pointer at 1 → order 0x13, 0x10, 0x11.
- Requester 1 sends packet 0x01, 0x02, 0x03 (last on 0x03) while requester 0 is valid with 0x55 → wire order 01 02 03 55; `req_ready_o[0]` stays 0 until the lock is released.
- Requester 1 drops valid for 50 cycles mid-packet → lock holds, `tx_en_o` silent, then the packet resumes.
- Assert `reset_i` during a data bit of the second packet byte → outputs return to reset values asynchronously; the next request sends cleanly from requester 0 priority.
